// File: rtl/id_decode_stage.sv
// Decode stage: register file, instruction decode, BEQ/JMP resolution, hazard detection and the ID/EX latch.
// Optional feature: define ID_STALL_CNT_EN to add a saturating stall_cnt output.
module id_decode_stage #(
    parameter int          DATA_W    = 16,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       id_instr,
    input  logic [15:0]       id_instr_addr,
    input  logic              wb_we,
    input  logic [2:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [2:0]        mem_rd,
    input  logic              mem_we,
    output logic              pc_wr_en,
    output logic              fe_latch_wr,
    output logic              fe_flush,
    output logic [1:0]        pc_sel,
    output logic [15:0]       branch_target,
    output logic [3:0]        ex_op,
    output logic [2:0]        ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr
`ifdef ID_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;

    logic [3:0]        op;
    logic [2:0]        rdIdx;
    logic [2:0]        rsIdx;
    logic [2:0]        rtIdx;
    logic [DATA_W-1:0] rdVal;
    logic [DATA_W-1:0] rsVal;
    logic [DATA_W-1:0] rtVal;
    logic [DATA_W-1:0] immExt;
    logic [15:0]       beqTarget;
    logic [15:0]       jmpTarget;

    logic readsRs;
    logic readsRt;
    logic readsRd;
    logic isBeq;
    logic isJmp;
    logic regWe;
    logic memRd;
    logic memWr;
    logic loadUse;
    logic branchStall;
    logic stall;
    logic redirect;

    logic [DATA_W-1:0] regs_q [8];

    logic [3:0]        exOp_q,    exOp_d;
    logic [2:0]        exRd_q,    exRd_d;
    logic [DATA_W-1:0] exA_q,     exA_d;
    logic [DATA_W-1:0] exB_q,     exB_d;
    logic [DATA_W-1:0] exImm_q,   exImm_d;
    logic              exRegWe_q, exRegWe_d;
    logic              exMemRd_q, exMemRd_d;
    logic              exMemWr_q, exMemWr_d;

    assign op    = id_instr[15:12];
    assign rdIdx = id_instr[11:9];
    assign rsIdx = id_instr[8:6];
    assign rtIdx = id_instr[5:3];

    // Register file; r0 is never written so it always reads back as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we && wb_rd != 3'd0) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Write-through: a register being written this cycle is read with its new value.
    assign rdVal = (rdIdx == 3'd0) ? '0 : (wb_we && wb_rd == rdIdx) ? wb_data : regs_q[rdIdx];
    assign rsVal = (rsIdx == 3'd0) ? '0 : (wb_we && wb_rd == rsIdx) ? wb_data : regs_q[rsIdx];
    assign rtVal = (rtIdx == 3'd0) ? '0 : (wb_we && wb_rd == rtIdx) ? wb_data : regs_q[rtIdx];

    assign immExt    = {{(DATA_W-6){id_instr[5]}}, id_instr[5:0]};
    assign beqTarget = id_instr_addr + {{9{id_instr[5]}}, id_instr[5:0], 1'b0};
    assign jmpTarget = id_instr_addr + {{3{id_instr[11]}}, id_instr[11:0], 1'b0};

    always_comb begin
        readsRs = 1'b0;
        readsRt = 1'b0;
        readsRd = 1'b0;
        isBeq   = 1'b0;
        isJmp   = 1'b0;
        regWe   = 1'b0;
        memRd   = 1'b0;
        memWr   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                readsRs = 1'b1;
                readsRt = 1'b1;
                regWe   = 1'b1;
            end
            OP_ADDI: begin
                readsRs = 1'b1;
                regWe   = 1'b1;
            end
            OP_LW: begin
                readsRs = 1'b1;
                regWe   = 1'b1;
                memRd   = 1'b1;
            end
            OP_SW: begin
                readsRs = 1'b1;
                readsRd = 1'b1;
                memWr   = 1'b1;
            end
            OP_BEQ: begin
                readsRs = 1'b1;
                readsRd = 1'b1;
                isBeq   = 1'b1;
            end
            OP_JMP: begin
                isJmp = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // BEQ compares in ID, so it must also wait for a producer still in EX/MEM.
    assign loadUse = exMemRd_q && (exRd_q != 3'd0) &&
                     ((readsRs && rsIdx == exRd_q) ||
                      (readsRt && rtIdx == exRd_q) ||
                      (readsRd && rdIdx == exRd_q));

    assign branchStall = isBeq &&
                         ((exRegWe_q && ((rdIdx != 3'd0 && rdIdx == exRd_q) ||
                                         (rsIdx != 3'd0 && rsIdx == exRd_q))) ||
                          (mem_we    && ((rdIdx != 3'd0 && rdIdx == mem_rd) ||
                                         (rsIdx != 3'd0 && rsIdx == mem_rd))));

    assign stall    = loadUse || branchStall;
    assign redirect = !stall && (isJmp || (isBeq && rdVal == rsVal));

    always_comb begin
        pc_wr_en      = 1'b1;
        fe_latch_wr   = 1'b1;
        fe_flush      = 1'b0;
        pc_sel        = 2'd0;
        branch_target = 16'h0000;
        if (!reset) begin
            branch_target = isJmp ? jmpTarget : beqTarget;
            if (stall) begin
                pc_wr_en    = 1'b0;
                fe_latch_wr = 1'b0;
            end else if (redirect) begin
                fe_flush = 1'b1;
                pc_sel   = 2'd1;
            end
        end
    end

    // Stalls and resolved redirects both turn the ID/EX slot into a bubble.
    always_comb begin
        exOp_d    = NOP_INSTR[15:12];
        exRd_d    = NOP_INSTR[11:9];
        exA_d     = '0;
        exB_d     = '0;
        exImm_d   = '0;
        exRegWe_d = 1'b0;
        exMemRd_d = 1'b0;
        exMemWr_d = 1'b0;
        if (!stall && !redirect) begin
            exOp_d    = op;
            exRd_d    = rdIdx;
            exA_d     = rsVal;
            exB_d     = (op == OP_SW) ? rdVal : rtVal;
            exImm_d   = immExt;
            exRegWe_d = regWe;
            exMemRd_d = memRd;
            exMemWr_d = memWr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exOp_q    <= '0;
            exRd_q    <= '0;
            exA_q     <= '0;
            exB_q     <= '0;
            exImm_q   <= '0;
            exRegWe_q <= 1'b0;
            exMemRd_q <= 1'b0;
            exMemWr_q <= 1'b0;
        end else begin
            exOp_q    <= exOp_d;
            exRd_q    <= exRd_d;
            exA_q     <= exA_d;
            exB_q     <= exB_d;
            exImm_q   <= exImm_d;
            exRegWe_q <= exRegWe_d;
            exMemRd_q <= exMemRd_d;
            exMemWr_q <= exMemWr_d;
        end
    end

    assign ex_op     = exOp_q;
    assign ex_rd     = exRd_q;
    assign ex_a      = exA_q;
    assign ex_b      = exB_q;
    assign ex_imm    = exImm_q;
    assign ex_reg_we = exRegWe_q;
    assign ex_mem_rd = exMemRd_q;
    assign ex_mem_wr = exMemWr_q;

`ifdef ID_STALL_CNT_EN
    logic [15:0] stallCnt_q, stallCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall && stallCnt_q != 16'hFFFF) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCnt_q <= 16'h0000;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// Randomized bench for id_decode_stage, checked against a rule-level reference model.
module tb_id_decode_stage;

    logic        clock;
    logic        reset;
    logic [15:0] id_instr;
    logic [15:0] id_instr_addr;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  mem_rd;
    logic        mem_we;
    logic        pc_wr_en;
    logic        fe_latch_wr;
    logic        fe_flush;
    logic [1:0]  pc_sel;
    logic [15:0] branch_target;
    logic [3:0]  ex_op;
    logic [2:0]  ex_rd;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] ex_imm;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
`ifdef ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
    int          mStallCnt;
`endif

    int errorCount;
    int checkCount;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        we;
        logic        mrd;
        logic        mwr;
        logic        bubble;
        logic        taken;
    } exModel_t;

    logic [15:0] mRegs [8];
    exModel_t    mEx;

    id_decode_stage dut (
        .clock         (clock),
        .reset         (reset),
        .id_instr      (id_instr),
        .id_instr_addr (id_instr_addr),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_rd        (mem_rd),
        .mem_we        (mem_we),
        .pc_wr_en      (pc_wr_en),
        .fe_latch_wr   (fe_latch_wr),
        .fe_flush      (fe_flush),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .ex_op         (ex_op),
        .ex_rd         (ex_rd),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_imm        (ex_imm),
        .ex_reg_we     (ex_reg_we),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr)
`ifdef ID_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] rtype(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] itype(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Set of registers an instruction reads, as a bitmask over r0..r7.
    function automatic logic [7:0] srcMask(input logic [15:0] instr);
        logic [7:0] m;
        int op;
        m  = 8'h00;
        op = int'(instr[15:12]);
        if (op <= 3) begin
            m[instr[8:6]] = 1'b1;
            m[instr[5:3]] = 1'b1;
        end else if (op == 4 || op == 5) begin
            m[instr[8:6]] = 1'b1;
        end else if (op == 6 || op == 7) begin
            m[instr[8:6]]  = 1'b1;
            m[instr[11:9]] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [15:0] readModel(input logic [2:0] idx);
        if (idx == 3'd0) return 16'h0000;
        if (wb_we && wb_rd == idx) return wb_data;
        return mRegs[idx];
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 8; i++) mRegs[i] = 16'h0000;
        mEx = '{op: 4'h0, rd: 3'd0, a: 16'h0, b: 16'h0, imm: 16'h0,
                we: 1'b0, mrd: 1'b0, mwr: 1'b0, bubble: 1'b1, taken: 1'b0};
`ifdef ID_STALL_CNT_EN
        mStallCnt = 0;
`endif
    endtask

    task automatic checkResetState();
        checkOutput("rst_pc_wr_en", pc_wr_en, 1);
        checkOutput("rst_fe_latch_wr", fe_latch_wr, 1);
        checkOutput("rst_fe_flush", fe_flush, 0);
        checkOutput("rst_pc_sel", pc_sel, 0);
        checkOutput("rst_branch_target", branch_target, 0);
        checkOutput("rst_ex_op", ex_op, 0);
        checkOutput("rst_ex_rd", ex_rd, 0);
        checkOutput("rst_ex_a", ex_a, 0);
        checkOutput("rst_ex_b", ex_b, 0);
        checkOutput("rst_ex_imm", ex_imm, 0);
        checkOutput("rst_ex_reg_we", ex_reg_we, 0);
        checkOutput("rst_ex_mem_rd", ex_mem_rd, 0);
        checkOutput("rst_ex_mem_wr", ex_mem_wr, 0);
`ifdef ID_STALL_CNT_EN
        checkOutput("rst_stall_cnt", stall_cnt, 0);
`endif
    endtask

    task automatic checkEx();
        if (mEx.bubble) begin
            checkOutput("bub_ex_op", ex_op, 0);
            checkOutput("bub_ex_rd", ex_rd, 0);
            checkOutput("bub_ex_mem_rd", ex_mem_rd, 0);
            checkOutput("bub_ex_mem_wr", ex_mem_wr, 0);
            if (!mEx.taken) checkOutput("bub_ex_reg_we", ex_reg_we, 0);
        end else begin
            checkOutput("ex_reg_we", ex_reg_we, mEx.we);
            checkOutput("ex_mem_rd", ex_mem_rd, mEx.mrd);
            checkOutput("ex_mem_wr", ex_mem_wr, mEx.mwr);
            if (mEx.op <= 4'd7) begin
                checkOutput("ex_op", ex_op, mEx.op);
                checkOutput("ex_imm", ex_imm, mEx.imm);
            end
            if (mEx.op <= 4'd6) checkOutput("ex_a", ex_a, mEx.a);
            if (mEx.op <= 4'd3 || mEx.op == 4'd6) checkOutput("ex_b", ex_b, mEx.b);
            if (mEx.we) checkOutput("ex_rd", ex_rd, mEx.rd);
        end
`ifdef ID_STALL_CNT_EN
        checkOutput("stall_cnt", stall_cnt, mStallCnt);
`endif
    endtask

    // Drives one instruction for one cycle; checks fetch control before the edge and ID/EX after it.
    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] addr,
                                 input logic wbWe, input logic [2:0] wbRd, input logic [15:0] wbData,
                                 input logic memWe, input logic [2:0] memRd);
        logic [7:0]  mask;
        logic [3:0]  op;
        logic        stall;
        logic        taken;
        logic [15:0] target;
        int          off;
        int          imm6;
        exModel_t    nx;

        id_instr      = instr;
        id_instr_addr = addr;
        wb_we         = wbWe;
        wb_rd         = wbRd;
        wb_data       = wbData;
        mem_we        = memWe;
        mem_rd        = memRd;

        op    = instr[15:12];
        mask  = srcMask(instr);
        stall = mEx.mrd && (mEx.rd != 3'd0) && mask[mEx.rd];
        if (op == 4'd7) begin
            mask[0] = 1'b0;
            if ((mEx.we && mask[mEx.rd]) || (memWe && mask[memRd])) stall = 1'b1;
        end
        taken = !stall && (op == 4'd8 ||
                           (op == 4'd7 && readModel(instr[11:9]) == readModel(instr[8:6])));

        imm6 = int'(instr[5:0]);
        if (imm6 >= 32) imm6 -= 64;
        if (op == 4'd8) begin
            off = int'(instr[11:0]);
            if (off >= 2048) off -= 4096;
        end else begin
            off = imm6;
        end
        target = 16'(int'(addr) + 2 * off);

        @(negedge clock);
        checkOutput("pc_wr_en", pc_wr_en, !stall);
        checkOutput("fe_latch_wr", fe_latch_wr, !stall);
        checkOutput("fe_flush", fe_flush, taken);
        checkOutput("pc_sel", pc_sel, taken ? 2'd1 : 2'd0);
        if (taken) checkOutput("branch_target", branch_target, target);

        nx = '{op: 4'h0, rd: 3'd0, a: 16'h0, b: 16'h0, imm: 16'h0,
               we: 1'b0, mrd: 1'b0, mwr: 1'b0, bubble: 1'b1, taken: taken};
        if (!stall && !taken) begin
            nx.bubble = 1'b0;
            nx.op     = op;
            nx.rd     = instr[11:9];
            nx.a      = readModel(instr[8:6]);
            nx.b      = (op == 4'd6) ? readModel(instr[11:9]) : readModel(instr[5:3]);
            nx.imm    = 16'(imm6);
            nx.we     = (op <= 4'd5);
            nx.mrd    = (op == 4'd5);
            nx.mwr    = (op == 4'd6);
        end
`ifdef ID_STALL_CNT_EN
        if (stall && mStallCnt < 65535) mStallCnt++;
`endif

        @(posedge clock);
        #1;
        if (wbWe && wbRd != 3'd0) mRegs[wbRd] = wbData;
        mEx = nx;
        checkEx();
    endtask

    task automatic randomCycle();
        logic [15:0] instr;
        instr = 16'($urandom);
        if (instr[15:12] == 4'd7 && $urandom_range(0, 3) == 0) instr[8:6] = instr[11:9];
        applyStimulus(instr, 16'($urandom),
                      ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 16'($urandom),
                      ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        resetModel();
        id_instr      = {4'h8, 12'h123};
        id_instr_addr = 16'h4000;
        wb_we         = 1'b0;
        wb_rd         = 3'd0;
        wb_data       = 16'h0000;
        mem_we        = 1'b0;
        mem_rd        = 3'd0;
        reset         = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkResetState();
        reset = 1'b0;

        // Every register reads zero after reset.
        applyStimulus(rtype(4'd0, 3'd1, 3'd1, 3'd2), 16'h0002, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(rtype(4'd1, 3'd3, 3'd3, 3'd4), 16'h0004, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(rtype(4'd2, 3'd5, 3'd5, 3'd6), 16'h0006, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(rtype(4'd3, 3'd7, 3'd7, 3'd0), 16'h0008, 0, 3'd0, 16'h0, 0, 3'd0);

        // Write-through bypass.
        applyStimulus(rtype(4'd0, 3'd1, 3'd3, 3'd0), 16'h000A, 1, 3'd3, 16'h00A5, 0, 3'd0);
        checkOutput("bypass_ex_a", ex_a, 16'h00A5);

        // Load-use: LW r2,0(r1) then ADD r4,r2,r2 stalls once.
        applyStimulus(itype(4'd5, 3'd2, 3'd1, 6'd0), 16'h000C, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(rtype(4'd0, 3'd4, 3'd2, 3'd2), 16'h000E, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(rtype(4'd0, 3'd4, 3'd2, 3'd2), 16'h000E, 0, 3'd0, 16'h0, 0, 3'd0);

        // r1 = r2 = 5, then taken BEQ with negative offset.
        applyStimulus(16'h0000, 16'h0010, 1, 3'd1, 16'd5, 0, 3'd0);
        applyStimulus(16'h0000, 16'h0010, 1, 3'd2, 16'd5, 0, 3'd0);
        applyStimulus(itype(4'd7, 3'd1, 3'd2, 6'h3E), 16'h0010, 0, 3'd0, 16'h0, 0, 3'd0);

        // Branch hazard through EX then MEM, then resolution.
        applyStimulus(itype(4'd4, 3'd1, 3'd1, 6'd0), 16'h001E, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(itype(4'd7, 3'd1, 3'd2, 6'h04), 16'h0020, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(itype(4'd7, 3'd1, 3'd2, 6'h04), 16'h0020, 0, 3'd0, 16'h0, 1, 3'd1);
        applyStimulus(itype(4'd7, 3'd1, 3'd2, 6'h04), 16'h0020, 0, 3'd0, 16'h0, 0, 3'd0);

        // JMP wrap and undefined opcode.
        applyStimulus({4'h8, 12'hFFF}, 16'h0000, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus({4'hC, 12'hABC}, 16'h0002, 0, 3'd0, 16'h0, 0, 3'd0);

        // Three load-use stalls: on an R-type, a store and a branch.
        applyStimulus(itype(4'd5, 3'd3, 3'd0, 6'd0), 16'h0030, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(rtype(4'd0, 3'd5, 3'd3, 3'd0), 16'h0032, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(rtype(4'd0, 3'd5, 3'd3, 3'd0), 16'h0032, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(itype(4'd5, 3'd4, 3'd0, 6'd2), 16'h0034, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(itype(4'd6, 3'd4, 3'd1, 6'd1), 16'h0036, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(itype(4'd6, 3'd4, 3'd1, 6'd1), 16'h0036, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(itype(4'd5, 3'd6, 3'd0, 6'd0), 16'h0038, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(itype(4'd7, 3'd6, 3'd0, 6'd3), 16'h003A, 0, 3'd0, 16'h0, 0, 3'd0);
        applyStimulus(itype(4'd7, 3'd6, 3'd0, 6'd3), 16'h003A, 0, 3'd0, 16'h0, 0, 3'd0);

        for (int i = 0; i < 400; i++) randomCycle();

        // Asynchronous reset in the middle of a cycle discards ID/EX.
        reset = 1'b1;
        #1;
        resetModel();
        checkResetState();
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 100; i++) randomCycle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
